conv_row_writer: RTL and testbench
==================================

Name: conv_row_writer

Overview:
Downstream writeback stage of the binary 3x3 convolution pipeline. Consumes one result bit per cycle from the majority-vote adder tree, together with the pipelined column index and output write address. Packs the bits into 16-bit output row words and issues single-cycle writes to the output SRAM. Reports rows written and a completion pulse to the controller.

Parameters:
DATA_W, 16, output word width; one bit per output column.
ADDR_W, 12, SRAM address width.
COL_W, 4, column index width; log2(DATA_W).

Ports:
clk  input  1  sole clock; all state on rising edge.
reset_b  input  1  reset: asynchronous, active-high.
start  input  1  one-cycle pulse; clears accumulator, mask and row counter; FSM enters ACCUM.
bit_valid  input  1  result beat present this cycle.
bit_value  input  1  result bit (1 = negative majority), stored verbatim.
col_idx  input  COL_W  bit position of the beat within the word.
row_waddr  input  ADDR_W  output address of the row this beat belongs to.
row_last  input  1  qualifies a beat as the final column of its row.
flush  input  1  end of image; write out any partial word.
dut_sram_write_enable  output  1  one-cycle write strobe.
dut_sram_write_address  output  ADDR_W  write address, valid with strobe.
dut_sram_write_data  output  DATA_W  packed row word, valid with strobe.
rows_written  output  ADDR_W  count of words written since start.
done  output  1  one-cycle completion pulse.
addr_err  output  1  sticky; row_waddr changed mid-row without row_last.

Behaviour:
- Reset (async, active-high): all outputs 0, accumulator 0, mask 0, row address 0, FSM IDLE.
- FSM states:
  - IDLE: beats ignored; start -> ACCUM.
  - ACCUM: beats accepted; flush -> DRAIN.
  - DRAIN: one cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - start in any state -> ACCUM with counters cleared. start has priority over flush.
- Accept (ACCUM, bit_valid=1):
  - acc[col_idx] <= bit_value; mask[col_idx] <= 1.
  - First beat of a row latches row_waddr.
  - A duplicate col_idx overwrites the earlier bit.
- Row completion: on a beat with row_last=1, the next cycle has:
  - write_enable=1;
  - address = latched row address (row_waddr of the current beat if it was the first beat of the row);
  - data = acc including the current beat, with unset positions forced 0.
  - acc and mask clear in the same edge that loads the write registers.
- Latency: exactly 1 cycle from the row_last beat to the write strobe. Write registers reload every cycle, so back-to-back rows (row_last on consecutive cycles) produce consecutive writes with no stall. The block never backpressures.
- Address change: a beat whose row_waddr differs from the latched address while mask!=0 and row_last was not seen:
  - the old partial word is written next cycle (old address);
  - the new beat starts a fresh word;
  - addr_err sets and stays set until start or reset.
- flush:
  - If mask!=0, or a beat is present in the same cycle (that beat is folded in first), one write issues next cycle.
  - flush coinciding with a row_last beat produces a single write, not two.
  - If mask==0 and no beat is present, no write issues.
  - done pulses in the cycle after DRAIN, i.e. 2 cycles after flush, which is one cycle after the final write.
- rows_written increments by 1 on every write strobe and wraps at 2^ADDR_W.
- Reset asserted mid-row discards the partial word; no write issues.

Decomposition:
- Shared package: DATA_W/ADDR_W/COL_W constants, FSM state encoding (IDLE, ACCUM, DRAIN, DONE), end-of-image marker 16'h00FF.
- One natural sub-module: row_pack_reg. It holds the accumulator, mask and address latch, and takes set/clear/bit-index inputs. The FSM, write registers and counter stay in the top.

Test Plan:
- Full row: start; 16 beats col 0..15 with bits 1,0 alternating (col0=1), row_waddr=12'h010, row_last on col 15 -> one write next cycle, addr 12'h010, data 16'h5555, rows_written=1.
- Back-to-back: row A (addr 12'h020, all 1, last on col 15) immediately followed by row B (addr 12'h021, all 0) -> writes on consecutive rows' final cycles +1: 16'hFFFF@020 then 16'h0000@021, no gap.
- Partial flush: beats cols 0..5 = 1 at addr 12'h030, then flush -> write 16'h003F@030 next cycle, done pulse the following cycle, rows_written=1.
- Empty flush: start, flush with no beats -> no write strobe; done pulses 2 cycles after flush; rows_written=0.
- Address jump: cols 0..3 = 1 at 12'h040, then col 0 = 1 at 12'h041 (no row_last) -> write 16'h000F@040, addr_err=1 sticky; new word holds bit 0.
- Async reset mid-row: after 7 beats, assert reset_b for half a cycle -> outputs 0 immediately; no write; subsequent start and full row behave as in the first scenario.

Source files
------------

// File: rtl/conv_row_writer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | conv_row_writer_pkg                                             |
// | Shared widths, FSM encoding and markers for the row writer.     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package conv_row_writer_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int COL_W  = 4;

  localparam logic [DATA_W-1:0] EOI_MARKER = 16'h00FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/conv_row_writer_row_pack_reg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | row_pack_reg                                                    |
// | Row word accumulator, valid-bit mask and row address latch.     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module row_pack_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int COL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              set_en,
  input  logic [COL_W-1:0]  bit_idx,
  input  logic              bit_val,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] mask,
  output logic [ADDR_W-1:0] addr
);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mask;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [DATA_W-1:0] w_mask_nxt;

  // Clear and set may coincide: the word restarts holding only the new bit.
  always_comb begin
    w_acc_nxt  = clear ? '0 : r_acc;
    w_mask_nxt = clear ? '0 : r_mask;
    if (set_en) begin
      w_acc_nxt[bit_idx]  = bit_val;
      w_mask_nxt[bit_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc  <= '0;
      r_mask <= '0;
      r_addr <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_mask <= w_mask_nxt;
      if (addr_load) r_addr <= addr_in;
    end
  end

  assign acc  = r_acc;
  assign mask = r_mask;
  assign addr = r_addr;

endmodule
`default_nettype wire

// File: rtl/conv_row_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | conv_row_writer                                                 |
// | Packs per-column result bits into row words and writes them.    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module conv_row_writer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int COL_W  = 4
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic              bit_valid,
  input  logic              bit_value,
  input  logic [COL_W-1:0]  col_idx,
  input  logic [ADDR_W-1:0] row_waddr,
  input  logic              row_last,
  input  logic              flush,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic [ADDR_W-1:0] rows_written,
  output logic              done,
  output logic              addr_err
);

  import conv_row_writer_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [ADDR_W-1:0] r_rows;
  logic              r_addr_err;

  logic [DATA_W-1:0] w_acc;
  logic [DATA_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_addr;
  logic              w_in_accum, w_accept, w_mask_nz, w_jump, w_fold, w_flush;
  logic              w_write, w_clear, w_set, w_addr_load;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [DATA_W-1:0] w_merge_acc;
  logic [DATA_W-1:0] w_merge_mask;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = ST_IDLE;
      ST_ACCUM: if (flush) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (start) w_state_nxt = ST_ACCUM;
  end

  always_comb begin
    w_in_accum   = (r_state == ST_ACCUM) && !start;
    w_accept     = w_in_accum && bit_valid;
    w_mask_nz    = |w_mask;
    // A row_last beat always closes its own row, so it never counts as a jump.
    w_jump       = w_accept && w_mask_nz && !row_last && (row_waddr != w_addr);
    w_fold       = w_accept && !w_jump;
    w_flush      = w_in_accum && flush;
    w_merge_acc  = w_acc;
    w_merge_mask = w_mask;
    if (w_fold) begin
      w_merge_acc[col_idx]  = bit_value;
      w_merge_mask[col_idx] = 1'b1;
    end

    w_write   = 1'b0;
    w_wr_addr = w_addr;
    w_wr_data = w_acc & w_mask;
    if (w_jump) begin
      w_write = 1'b1;
    end else if (w_fold && (row_last || flush)) begin
      w_write   = 1'b1;
      w_wr_addr = w_mask_nz ? w_addr : row_waddr;
      w_wr_data = w_merge_acc & w_merge_mask;
    end else if ((w_flush || (r_state == ST_DRAIN && !start)) && w_mask_nz) begin
      // DRAIN picks up a word restarted by a jump in the flush cycle.
      w_write = 1'b1;
    end

    w_clear     = start || w_write;
    w_set       = w_jump || (w_fold && !w_write);
    w_addr_load = w_set && (w_jump || !w_mask_nz);
  end

  row_pack_reg #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .COL_W  (COL_W)
  ) u_pack (
    .clk       (clk),
    .rst       (reset_b),
    .clear     (w_clear),
    .set_en    (w_set),
    .bit_idx   (col_idx),
    .bit_val   (bit_value),
    .addr_load (w_addr_load),
    .addr_in   (row_waddr),
    .acc       (w_acc),
    .mask      (w_mask),
    .addr      (w_addr)
  );

  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rows     <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_we       <= w_write;
      r_waddr    <= w_wr_addr;
      r_wdata    <= w_wr_data;
      r_rows     <= start ? '0 : r_rows + {{(ADDR_W-1){1'b0}}, w_write};
      r_addr_err <= start ? 1'b0 : (r_addr_err | w_jump);
    end
  end

  assign dut_sram_write_enable  = r_we;
  assign dut_sram_write_address = r_waddr;
  assign dut_sram_write_data    = r_wdata;
  assign rows_written           = r_rows;
  assign done                   = (r_state == ST_DONE);
  assign addr_err               = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_row_writer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_conv_row_writer                                              |
// | Directed and random stimulus against a row-level model.         |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_conv_row_writer;

  logic        clk;
  logic        reset_b;
  logic        start, bit_valid, bit_value, row_last, flush;
  logic [3:0]  col_idx;
  logic [11:0] row_waddr;
  logic        we;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic [11:0] rows_written;
  logic        done, addr_err;

  conv_row_writer dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .start                  (start),
    .bit_valid              (bit_valid),
    .bit_value              (bit_value),
    .col_idx                (col_idx),
    .row_waddr              (row_waddr),
    .row_last               (row_last),
    .flush                  (flush),
    .dut_sram_write_enable  (we),
    .dut_sram_write_address (waddr),
    .dut_sram_write_data    (wdata),
    .rows_written           (rows_written),
    .done                   (done),
    .addr_err               (addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [11:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_q[$];
  int  exp_done[$];
  int  act_done[$];

  always @(negedge clk) begin
    wr_t w;
    if (we === 1'b1) begin
      w.c = cyc; w.a = waddr; w.d = wdata;
      act_q.push_back(w);
    end
    if (done === 1'b1) act_done.push_back(cyc);
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row-level model: a set of known column bits plus the row's address.
  bit m_bits[16];
  bit m_set[16];
  int m_addr = 0;
  bit m_err  = 0;
  int m_rows = 0;
  int m_mode = 0;

  function automatic bit m_active();
    bit r = 0;
    for (int i = 0; i < 16; i++) if (m_set[i]) r = 1;
    return r;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 16; i++) begin m_bits[i] = 0; m_set[i] = 0; end
  endfunction

  function automatic void m_emit(input int c);
    wr_t w;
    w.c = c; w.a = 12'(m_addr); w.d = 16'h0;
    for (int i = 0; i < 16; i++) if (m_set[i] && m_bits[i]) w.d = w.d | (16'h1 << i);
    exp_q.push_back(w);
    m_rows++;
    m_clear();
  endfunction

  function automatic void model_step(input bit s, v, val, input int c, input int a, input bit l, f);
    if (s) begin
      m_clear(); m_rows = 0; m_err = 0; m_mode = 1;
      return;
    end
    case (m_mode)
      1: begin
        if (v) begin
          if (m_active() && a != m_addr && !l) begin m_emit(cyc + 1); m_err = 1; end
          if (!m_active()) m_addr = a;
          m_bits[c] = val; m_set[c] = 1;
          if (l || f) m_emit(cyc + 1);
        end else if (f && m_active()) begin
          m_emit(cyc + 1);
        end
        if (f) begin m_mode = 2; exp_done.push_back(cyc + 2); end
      end
      2: m_mode = 3;
      3: m_mode = 0;
      default: ;
    endcase
  endfunction

  task automatic drive(input bit s, v, val, input int c, input logic [11:0] a, input bit l, f);
    @(posedge clk); #1;
    start = s; bit_valid = v; bit_value = val; col_idx = c[3:0];
    row_waddr = a; row_last = l; flush = f;
    model_step(s, v, val, c, int'(a), l, f);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 12'h000, 0, 0);
  endtask

  task automatic compare(input string tag);
    int n;
    idle(4);
    chk($sformatf("%s_nwr", tag), 32'(act_q.size()), 32'(exp_q.size()));
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_wr%0d_addr", tag, i), 32'(act_q[i].a), 32'(exp_q[i].a));
      chk($sformatf("%s_wr%0d_data", tag, i), 32'(act_q[i].d), 32'(exp_q[i].d));
      chk($sformatf("%s_wr%0d_cyc",  tag, i), 32'(act_q[i].c), 32'(exp_q[i].c));
    end
    chk($sformatf("%s_ndone", tag), 32'(act_done.size()), 32'(exp_done.size()));
    n = (act_done.size() < exp_done.size()) ? act_done.size() : exp_done.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_done%0d_cyc", tag, i), 32'(act_done[i]), 32'(exp_done[i]));
    chk($sformatf("%s_rows", tag), 32'(rows_written), 32'(m_rows % 4096));
    chk($sformatf("%s_addr_err", tag), 32'(addr_err), 32'(m_err));
    act_q.delete(); exp_q.delete(); act_done.delete(); exp_done.delete();
  endtask

  task automatic full_row_5555();
    drive(1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, (i % 2) == 0, i, 12'h010, i == 15, 0);
  endtask

  task automatic random_round(input bit end_with_last);
    logic [11:0] a;
    drive(1, 0, 0, 0, 12'h000, 0, 0);
    a = 12'($urandom_range(0, 4095));
    repeat (80) begin
      if ($urandom_range(0, 11) == 0) a = 12'($urandom_range(0, 4095));
      drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)), a, $urandom_range(0, 9) == 0, 0);
    end
    if (end_with_last) drive(0, 1, 1, int'($urandom_range(0, 15)), a, 1, 1);
    else               drive(0, 0, 0, 0, 12'h000, 0, 1);
  endtask

  initial begin
    reset_b = 1'b1;
    start = 0; bit_valid = 0; bit_value = 0; col_idx = 0;
    row_waddr = 0; row_last = 0; flush = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we",    32'(we), 32'd0);
    chk("reset_addr",  32'(waddr), 32'd0);
    chk("reset_data",  32'(wdata), 32'd0);
    chk("reset_rows",  32'(rows_written), 32'd0);
    chk("reset_done",  32'(done), 32'd0);
    chk("reset_err",   32'(addr_err), 32'd0);
    @(negedge clk);
    reset_b = 1'b0;
    idle(2);

    full_row_5555();
    compare("full");

    drive(1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 1, i, 12'h020, i == 15, 0);
    for (int i = 0; i < 16; i++) drive(0, 1, 0, i, 12'h021, i == 15, 0);
    drive(0, 1, 1, 3, 12'h022, 1, 0);
    drive(0, 1, 1, 5, 12'h023, 1, 0);
    compare("b2b");

    drive(1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 1, i, 12'h030, 0, 0);
    drive(0, 0, 0, 0, 12'h000, 0, 1);
    compare("partial");

    drive(1, 0, 0, 0, 12'h000, 0, 0);
    drive(0, 0, 0, 0, 12'h000, 0, 1);
    compare("empty");

    drive(1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 1, i, 12'h040, 0, 0);
    drive(0, 1, 1, 0, 12'h041, 0, 0);
    compare("jump");
    drive(0, 0, 0, 0, 12'h000, 0, 1);
    compare("jump_flush");
    for (int i = 0; i < 3; i++) drive(0, 1, 1, i, 12'h050, 1, 0);
    compare("idle_beats");
    drive(1, 0, 0, 0, 12'h000, 0, 0);
    compare("err_clear");

    drive(1, 0, 0, 0, 12'h000, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 1, i, 12'h060, 0, 0);
    @(negedge clk);
    #1 reset_b = 1'b1;
    #1;
    chk("areset_we",   32'(we), 32'd0);
    chk("areset_data", 32'(wdata), 32'd0);
    chk("areset_addr", 32'(waddr), 32'd0);
    chk("areset_done", 32'(done), 32'd0);
    m_clear(); m_mode = 0; m_rows = 0; m_err = 0;
    #1 reset_b = 1'b0;
    compare("areset");
    full_row_5555();
    compare("after_reset");

    random_round(0);
    compare("rand0");
    random_round(1);
    compare("rand1");
    random_round(0);
    compare("rand2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
